stream_fifo_reader_monitor: RTL and testbench
=============================================

Name: stream_fifo_reader_monitor

Overview:
- Read-side companion to the streaming FIFOs: consumes an AXI-Stream FIFO output and forwards it downstream through a registered 2-entry skid stage.
- Samples the FIFO's occupancy count and records high-water mark, beat count and backpressure stall cycles.
- Statistics feed FIFO depth sizing after a run.
- Sits between a FIFO and the next compute layer; inserting it does not alter data or ordering.

Parameters:
- WIDTH, 8, stream data width in bits.
- COUNT_W, 14, width of the FIFO occupancy count input (log2 of the FIFO depth).
- STAT_W, 32, width of the beat and stall statistic counters.

Ports:
- ap_clk  input  1  clock, all logic on rising edge.
- ap_rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous statistics clear; the data path is unaffected.
- fifo_count  input  COUNT_W  occupancy count from the upstream FIFO.
- in0_V_V_TDATA  input  WIDTH  upstream data.
- in0_V_V_TVALID  input  1  upstream valid.
- in0_V_V_TREADY  output  1  ready to upstream FIFO.
- out_V_V_TDATA  output  WIDTH  downstream data.
- out_V_V_TVALID  output  1  downstream valid.
- out_V_V_TREADY  input  1  downstream ready.
- max_count  output  COUNT_W  high-water mark of fifo_count.
- beat_count  output  STAT_W  number of output handshakes, saturating.
- stall_cycles  output  STAT_W  number of cycles with out valid and not ready, saturating.

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - skid stage empty; out_V_V_TVALID=0; in0_V_V_TREADY=0 during reset and 1 the cycle after.
  - out_V_V_TDATA=0; max_count=0; beat_count=0; stall_cycles=0.
  - Reset mid-transfer discards any buffered beats; no partial output.
- Data path: two-entry skid buffer, states EMPTY, ONE, TWO.
  - in0_V_V_TREADY is a register output: 1 in EMPTY and ONE, 0 in TWO. It never depends combinationally on out_V_V_TREADY.
  - Input handshake = in TVALID & in TREADY. Output handshake = out TVALID & out TREADY.
  - EMPTY: on input handshake go to ONE. out TVALID=1 the next cycle with the captured data, so latency is 1 cycle.
  - ONE with input handshake only: go to TWO.
  - ONE with output handshake only: go to EMPTY.
  - ONE with both handshakes: stay in ONE; the new beat becomes head.
  - TWO: output handshake moves to ONE; the second entry becomes head the next cycle.
  - out_V_V_TVALID=1 in ONE and TWO. out TDATA stays stable while valid and not ready.
  - Order is strictly FIFO. Throughput is 1 beat/cycle with out TREADY held high.
- max_count:
  - Each cycle, if fifo_count > max_count then max_count <= fifo_count.
  - Unsigned compare. Never decreases except on clear or reset.
- beat_count: +1 per output handshake; holds at all-ones once reached.
- stall_cycles: +1 per cycle with out TVALID=1 and out TREADY=0; holds at all-ones.
- clear (when ap_rst=0):
  - Next cycle: max_count <= fifo_count sampled that cycle; beat_count=0; stall_cycles=0.
  - clear overrides same-cycle increments.
  - The skid state is unchanged.
- ap_rst has priority over clear.

Optional Feature:
- Macro MONITOR_STALL_CNT_EN.
- Defined: stall_cycles counter implemented as above.
- Undefined: stall counter logic is omitted and stall_cycles is tied to 0. The port remains so the interface is identical.

Test Plan:
- Reset, then 4 beats 0x11,0x22,0x33,0x44 with out TREADY=1 held: out shows 0x11..0x44 on consecutive cycles, first one cycle after its input handshake; beat_count=4, stall_cycles=0.
- out TREADY=0 while pushing 3 beats: in TREADY drops after 2 accepted; out TDATA holds 0x11. After 5 stalled cycles, raise ready: 0x11,0x22 drain, then the third beat is accepted; stall_cycles=5 (0 if the macro is undefined).
- fifo_count sequence 3,9,7,12,2: max_count=12 two cycles after the 12 is presented, and stays 12.
- clear asserted with fifo_count=5 while beats flow: next cycle max_count=5, beat_count=0, stall_cycles=0; data stream continues uninterrupted and in order.
- STAT_W=4, 20 beats: beat_count saturates at 15.
- Assert ap_rst with two beats buffered: out TVALID=0 and all statistics 0 the next cycle; the buffered beats never appear.

Source files
------------

// File: rtl/stream_fifo_reader_monitor.sv
// rtl/stream_fifo_reader_monitor.sv - FIFO read-side skid stage with occupancy/beat/stall statistics
//
// Purpose:
//   Takes beats from an upstream streaming FIFO and passes them downstream
//   through a registered two-entry skid buffer. Data and ordering are
//   unchanged. The block also collects run statistics used to size the FIFO:
//   the high-water mark of the FIFO occupancy, the number of output beats,
//   and the number of output backpressure cycles.
//
// Optional build macro:
//   MONITOR_STALL_CNT_EN - when defined, stall_cycles counts cycles with
//                          out valid and not ready. When undefined, the
//                          counter is not built and stall_cycles reads 0.
//
// Ports:
//   ap_clk          clock, rising edge
//   ap_rst          synchronous active-high reset
//   clear           synchronous statistics clear (data path unaffected)
//   fifo_count      upstream FIFO occupancy
//   in0_V_V_TDATA   upstream data
//   in0_V_V_TVALID  upstream valid
//   in0_V_V_TREADY  ready to upstream (registered)
//   out_V_V_TDATA   downstream data
//   out_V_V_TVALID  downstream valid
//   out_V_V_TREADY  downstream ready
//   max_count       high-water mark of fifo_count
//   beat_count      output handshakes, saturating
//   stall_cycles    out valid & !ready cycles, saturating
module stream_fifo_reader_monitor #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 14,
  parameter int STAT_W  = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               clear,
  input  logic [COUNT_W-1:0] fifo_count,
  input  logic [WIDTH-1:0]   in0_V_V_TDATA,
  input  logic               in0_V_V_TVALID,
  output logic               in0_V_V_TREADY,
  output logic [WIDTH-1:0]   out_V_V_TDATA,
  output logic               out_V_V_TVALID,
  input  logic               out_V_V_TREADY,
  output logic [COUNT_W-1:0] max_count,
  output logic [STAT_W-1:0]  beat_count,
  output logic [STAT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   head_q, head_d;
  logic [WIDTH-1:0]   tail_q, tail_d;
  logic               in_ready_q, in_ready_d;
  logic               in_hs, out_hs;

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] max_q;
  logic [STAT_W-1:0]  beat_q;

  assign out_V_V_TVALID = (state_q != S_EMPTY);
  assign out_V_V_TDATA  = head_q;
  assign in0_V_V_TREADY = in_ready_q;

  assign in_hs  = in0_V_V_TVALID & in_ready_q;
  assign out_hs = out_V_V_TVALID & out_V_V_TREADY;

  // State and data registers of the skid buffer. The head register always
  // drives the output, so TDATA cannot change while valid is held unacked.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_hs) begin
          head_d  = in0_V_V_TDATA;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_hs && out_hs) begin
          head_d = in0_V_V_TDATA;
        end else if (in_hs) begin
          tail_d  = in0_V_V_TDATA;
          state_d = S_TWO;
        end else if (out_hs) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // Ready is low here, so only the output side can move.
        if (out_hs) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    // Ready is computed from the next state so it is a pure register output
    // with no combinational path from out_V_V_TREADY.
    in_ready_d = (state_d != S_TWO);
  end

  // Occupancy is registered once before the compare, so a new peak shows
  // in max_count two cycles after it appears on fifo_count. Clear loads the
  // raw count of its own cycle.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      count_q <= '0;
      max_q   <= '0;
    end else begin
      count_q <= fifo_count;
      if (clear) begin
        max_q <= fifo_count;
      end else if (count_q > max_q) begin
        max_q <= count_q;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst || clear) begin
      beat_q <= '0;
    end else if (out_hs && !(&beat_q)) begin
      beat_q <= beat_q + STAT_ONE;
    end
  end

  assign max_count  = max_q;
  assign beat_count = beat_q;

`ifdef MONITOR_STALL_CNT_EN
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || clear) begin
      stall_q <= '0;
    end else if (out_V_V_TVALID && !out_V_V_TREADY && !(&stall_q)) begin
      stall_q <= stall_q + STAT_ONE;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stream_fifo_reader_monitor.sv
// tb/tb_stream_fifo_reader_monitor.sv - scoreboard bench for stream_fifo_reader_monitor
module tb_stream_fifo_reader_monitor;

`ifdef MONITOR_STALL_CNT_EN
  localparam int EXP_STALL = 5;
`else
  localparam int EXP_STALL = 0;
`endif

  logic        clk = 1'b0;
  logic        ap_rst;
  logic        clear;
  logic [13:0] fifo_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] max_cnt;
  logic [31:0] beat_cnt;
  logic [31:0] stall_cnt;

  logic        in_ready2;
  logic [7:0]  out_data2;
  logic        out_valid2;
  logic [13:0] max_cnt2;
  logic [3:0]  beat_cnt2;
  logic [3:0]  stall_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  stream_fifo_reader_monitor dut (
    .ap_clk(clk), .ap_rst(ap_rst), .clear(clear), .fifo_count(fifo_count),
    .in0_V_V_TDATA(in_data), .in0_V_V_TVALID(in_valid), .in0_V_V_TREADY(in_ready),
    .out_V_V_TDATA(out_data), .out_V_V_TVALID(out_valid), .out_V_V_TREADY(out_ready),
    .max_count(max_cnt), .beat_count(beat_cnt), .stall_cycles(stall_cnt)
  );

  stream_fifo_reader_monitor #(.STAT_W(4)) dut4 (
    .ap_clk(clk), .ap_rst(ap_rst), .clear(clear), .fifo_count(fifo_count),
    .in0_V_V_TDATA(in_data), .in0_V_V_TVALID(in_valid), .in0_V_V_TREADY(in_ready2),
    .out_V_V_TDATA(out_data2), .out_V_V_TVALID(out_valid2), .out_V_V_TREADY(out_ready),
    .max_count(max_cnt2), .beat_count(beat_cnt2), .stall_cycles(stall_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers one beat starting just after a rising edge; the expected value is
  // queued at the negedge where the handshake is known to happen.
  task automatic send(input logic [7:0] d);
    bit done = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: beat %0h not accepted", d);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int fc_seq[5] = '{3, 9, 7, 12, 2};
    ap_rst = 1'b1; clear = 1'b0; fifo_count = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!ap_rst && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected none", out_data);
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_max", max_cnt, 0);
    check("rst_beat", beat_cnt, 0);
    check("rst_stall", stall_cnt, 0);
    ap_rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Back-to-back beats with downstream always ready.
    out_ready = 1'b1;
    send(8'h11);
    check("latency_valid", out_valid, 1);
    check("latency_data", out_data, 8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    wait_drain();
    check("t1_beat", beat_cnt, 4);
    check("t1_stall", stall_cnt, 0);

    // Backpressure: two beats fill the skid, third waits for drain.
    out_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    fork
      send(8'h33);
      begin
        @(negedge clk);
        check("t2_in_ready_low", in_ready, 0);
        check("t2_hold_data", out_data, 8'h11);
        check("t2_hold_valid", out_valid, 1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("t2_stall", stall_cnt, EXP_STALL);
    check("t2_beat", beat_cnt, 7);

    // High-water mark, two-cycle latency.
    for (int i = 0; i < 5; i++) begin
      fifo_count = 14'(fc_seq[i]);
      if (i == 4) check("t3_max_before", max_cnt, 9);
      @(posedge clk);
      #1;
    end
    check("t3_max_12", max_cnt, 12);
    repeat (3) @(posedge clk);
    #1;
    check("t3_max_hold", max_cnt, 12);

    // Clear in the middle of a flowing stream.
    fork
      for (int k = 0; k < 6; k++) send(8'(8'h50 + k));
      begin
        repeat (3) @(posedge clk);
        #1;
        fifo_count = 14'd5;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("t4_max", max_cnt, 5);
        check("t4_beat", beat_cnt, 0);
        check("t4_stall", stall_cnt, 0);
      end
    join
    wait_drain();
    check("t4_beat_after", beat_cnt, 3);

    // Saturation of a 4-bit beat counter.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int k = 0; k < 20; k++) send(8'(k + 1));
    wait_drain();
    check("t5_beat_sat", beat_cnt2, 15);
    check("t5_beat_wide", beat_cnt, 20);
    check("t5_stall4", stall_cnt2, 0);
    check("t5_max4", max_cnt2, max_cnt);
    check("t5_ready4", in_ready2, in_ready);
    check("t5_valid4", out_valid2, out_valid);

    // Reset with two beats buffered: they must be discarded.
    out_ready = 1'b0;
    send(8'hA1);
    send(8'hA2);
    check("t6_full", in_ready, 0);
    ap_rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_data", out_data, 0);
    check("t6_max", max_cnt, 0);
    check("t6_beat", beat_cnt, 0);
    check("t6_stall", stall_cnt, 0);
    ap_rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_ready_after", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_output", out_valid, 0);
    check("t6_beat_after", beat_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
